// File: rtl/serial_addr_subtr_if.sv
// Request/result bundle between an arithmetic sequencer (master) and the
// bit-serial adder/subtractor (slave).
interface serial_addr_subtr_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             control_signal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_diff;
    logic             br_Ca_out;
    logic             neg;
    logic [WIDTH-1:0] magnitude;

    modport master (
        output start, a, b, control_signal,
        input  busy, done, sum_diff, br_Ca_out, neg, magnitude
    );

    modport slave (
        input  start, a, b, control_signal,
        output busy, done, sum_diff, br_Ca_out, neg, magnitude
    );
endinterface

// File: rtl/serial_addr_subtr.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// with the subtract result also decoded into sign and magnitude.
module serial_addr_subtr #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    serial_addr_subtr_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, bShift_q, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sub_q, carry_q;
    logic             done_q, carryOut_q, neg_q;
    logic [WIDTH-1:0] sumDiff_q, mag_q;

    logic             bitB, sumBit, carryNext, negNext;
    logic [WIDTH-1:0] magNext;
    logic             busy;

    // The carry flop is preloaded with the subtract flag, so the +1 of the
    // two's complement rides in through the first bit's carry-in.
    always_comb begin
        bitB      = bShift_q[0] ^ sub_q;
        sumBit    = aShift_q[0] ^ bitB ^ carry_q;
        carryNext = (aShift_q[0] & bitB) | (aShift_q[0] & carry_q) | (bitB & carry_q);
        negNext   = sub_q & ~carry_q;
        magNext   = negNext ? (~res_q + WIDTH'(1)) : res_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            done_q     <= 1'b0;
            carryOut_q <= 1'b0;
            neg_q      <= 1'b0;
            sumDiff_q  <= '0;
            mag_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        aShift_q <= bus.a;
                        bShift_q <= bus.b;
                        sub_q    <= bus.control_signal;
                        carry_q  <= bus.control_signal;
                        cnt_q    <= '0;
                    end
                end
                SHIFT: begin
                    res_q    <= {sumBit, res_q[WIDTH-1:1]};
                    aShift_q <= {1'b0, aShift_q[WIDTH-1:1]};
                    bShift_q <= {1'b0, bShift_q[WIDTH-1:1]};
                    carry_q  <= carryNext;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    sumDiff_q  <= res_q;
                    carryOut_q <= carry_q;
                    neg_q      <= negNext;
                    mag_q      <= magNext;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.sum_diff  = sumDiff_q;
    assign bus.br_Ca_out = carryOut_q;
    assign bus.neg       = neg_q;
    assign bus.magnitude = mag_q;
endmodule

// File: tb/tb_serial_addr_subtr.sv
// Directed vectors, handshake corner cases and an exhaustive sweep for the
// bit-serial adder/subtractor.
module tb_serial_addr_subtr;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   latency;

    serial_addr_subtr_if #(.WIDTH(WIDTH)) bus();

    serial_addr_subtr #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] expSum;
        logic       expCarry;
        logic       expNeg;
        logic [3:0] expMag;
        string      name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Presents one request at a negedge and waits (bounded) for its done pulse.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic m, input string name);
        bus.a              = a;
        bus.b              = b;
        bus.control_signal = m;
        bus.start          = 1'b1;
        latency            = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0;
                check({name, " busy"}, 32'(bus.busy), 32'd1);
            end
            if (bus.done === 1'b1) begin
                latency = n;
                break;
            end
        end
        check({name, " latency"}, latency, 32'd6);
        check({name, " busy at done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkOutput(input logic [3:0] expSum, input logic expCarry, input logic expNeg,
                               input logic [3:0] expMag, input string name);
        check({name, " sum_diff"}, 32'(bus.sum_diff), 32'(expSum));
        check({name, " br_Ca_out"}, 32'(bus.br_Ca_out), 32'(expCarry));
        check({name, " neg"}, 32'(bus.neg), 32'(expNeg));
        check({name, " magnitude"}, 32'(bus.magnitude), 32'(expMag));
        @(negedge clk);
        check({name, " done width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int          dones;
        int          j;
        logic [4:0]  full;
        logic [3:0]  bx;
        logic        eNeg;
        logic [3:0]  eMag;

        vecs[0] = '{4'd9,  4'd8,  1'b0, 4'd1,  1'b1, 1'b0, 4'd1,  "add 9+8"};
        vecs[1] = '{4'd10, 4'd3,  1'b1, 4'd7,  1'b1, 1'b0, 4'd7,  "sub 10-3"};
        vecs[2] = '{4'd3,  4'd5,  1'b1, 4'd14, 1'b0, 1'b1, 4'd2,  "sub 3-5"};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0, 4'd14, "add 15+15"};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd0,  1'b1, 1'b0, 4'd0,  "sub 15-15"};
        vecs[5] = '{4'd0,  4'd15, 1'b1, 4'd1,  1'b0, 1'b1, 4'd15, "sub 0-15"};
        vecs[6] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  "add 0+0"};
        vecs[7] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b0, 4'd8,  "add 5+3"};
        vecs[8] = '{4'd7,  4'd2,  1'b1, 4'd5,  1'b1, 1'b0, 4'd5,  "sub 7-2"};

        bus.start          = 1'b0;
        bus.a              = '0;
        bus.b              = '0;
        bus.control_signal = 1'b0;
        rst                = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum_diff", 32'(bus.sum_diff), 32'd0);
        check("reset br_Ca_out", 32'(bus.br_Ca_out), 32'd0);
        check("reset neg", 32'(bus.neg), 32'd0);
        check("reset magnitude", 32'(bus.magnitude), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].name);
            checkOutput(vecs[i].expSum, vecs[i].expCarry, vecs[i].expNeg, vecs[i].expMag, vecs[i].name);
        end

        // Reset and start on the same edge: reset wins and clears the 7-2 result.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 4'd5;
        @(negedge clk);
        check("rst vs start busy", 32'(bus.busy), 32'd0);
        check("rst vs start sum_diff", 32'(bus.sum_diff), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        // Operand churn and a stray start while busy must not disturb 6-1.
        bus.a = 4'd6; bus.b = 4'd1; bus.control_signal = 1'b1; bus.start = 1'b1;
        latency = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1) begin bus.start = 1'b0; bus.a = 4'd15; bus.b = 4'd15; bus.control_signal = 1'b0; end
            if (n == 2) bus.start = 1'b1;
            if (n == 3) begin bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd9; end
            if (bus.done === 1'b1) begin latency = n; break; end
        end
        check("churn latency", latency, 32'd6);
        checkOutput(4'd5, 1'b1, 1'b0, 4'd5, "churn 6-1");
        check("churn no queued start", 32'(bus.busy), 32'd0);

        // start held high: a new operation every 6 cycles with fresh operands.
        for (int n = 0; n <= 18; n++) begin
            if (n > 0) begin
                @(negedge clk);
                if (n % 6 == 0) begin
                    j = (n / 6 == 1) ? 0 : (n / 6 == 2) ? 2 : 5;
                    check({"b2b done ", vecs[j].name}, 32'(bus.done), 32'd1);
                    check({"b2b sum ", vecs[j].name}, 32'(bus.sum_diff), 32'(vecs[j].expSum));
                    check({"b2b carry ", vecs[j].name}, 32'(bus.br_Ca_out), 32'(vecs[j].expCarry));
                    check({"b2b neg ", vecs[j].name}, 32'(bus.neg), 32'(vecs[j].expNeg));
                    check({"b2b mag ", vecs[j].name}, 32'(bus.magnitude), 32'(vecs[j].expMag));
                end else begin
                    check("b2b done low", 32'(bus.done), 32'd0);
                end
            end
            if (n % 6 == 0 && n < 18) begin
                j = (n == 0) ? 0 : (n == 6) ? 2 : 5;
                bus.a = vecs[j].a; bus.b = vecs[j].b; bus.control_signal = vecs[j].m;
            end else begin
                bus.a = 4'($urandom); bus.b = 4'($urandom); bus.control_signal = 1'($urandom);
            end
            bus.start = (n < 18);
        end
        @(negedge clk);
        check("b2b idle after", 32'(bus.busy), 32'd0);

        // Reset in the third SHIFT cycle aborts the operation.
        bus.a = 4'd15; bus.b = 4'd15; bus.control_signal = 1'b0; bus.start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 3) rst = 1'b1;
        end
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort sum_diff", 32'(bus.sum_diff), 32'd0);
        check("abort br_Ca_out", 32'(bus.br_Ca_out), 32'd0);
        check("abort neg", 32'(bus.neg), 32'd0);
        check("abort magnitude", 32'(bus.magnitude), 32'd0);
        rst   = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("abort no done", dones, 32'd0);
        applyStimulus(4'd7, 4'd2, 1'b1, "post-abort 7-2");
        checkOutput(4'd5, 1'b1, 1'b0, 4'd5, "post-abort 7-2");

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int im = 0; im < 2; im++) begin
                    bx   = 4'(ib) ^ {4{im[0]}};
                    full = 5'(ia) + 5'(bx) + 5'(im);
                    eNeg = im[0] && (ia < ib);
                    eMag = eNeg ? 4'(ib - ia) : full[3:0];
                    applyStimulus(4'(ia), 4'(ib), im[0], "sweep");
                    checkOutput(full[3:0], full[4], eNeg, eMag, "sweep");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/serial_addr_subtr.md
Name: serial_addr_subtr

Overview:
- Bit-serial, multi-cycle version of the 4-bit gate-level adder/subtractor, with a start/done handshake.
- Processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Also decodes the subtract result into sign plus magnitude in hardware, so downstream logic does not re-derive the two's complement.
- Sits between a sequencer issuing arithmetic requests and consumers that need signed results.

Parameters:
- WIDTH, 4, operand and result width in bits; legal for any value of 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only while idle.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- control_signal  input  1  0 = add (A+B), 1 = subtract (A-B); captured on the accepted start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- sum_diff  output  WIDTH  raw sum or two's-complement difference.
- br_Ca_out  output  1  carry out of the MSB. Add: carry. Subtract: 1 means A>=B (no borrow), 0 means negative.
- neg  output  1  control_signal & ~br_Ca_out for the completed operation.
- magnitude  output  WIDTH  neg ? (~sum_diff + 1) : sum_diff, truncated to WIDTH bits.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state goes to IDLE.
  - busy, done, sum_diff, br_Ca_out, neg and magnitude all become 0.
  - Internal shift registers, bit counter and carry flip-flop are cleared.
  - Reset overrides start on the same edge.
- FSM states: IDLE, SHIFT, FIX.
- IDLE:
  - On an edge with start=1, latch a, b and control_signal into the operand shift registers.
  - Carry flip-flop loads control_signal; bit counter loads 0; next state SHIFT; busy=1.
  - With start=0, stay in IDLE; outputs hold their last values.
- SHIFT, one edge per bit i = 0..WIDTH-1:
  - bi' = b[i] XOR M.
  - s_i = a[i] ^ bi' ^ c; c <= majority(a[i], bi', c).
  - s_i shifts into the result register from the MSB end; the counter increments.
  - After the edge that processes bit WIDTH-1, next state is FIX.
- FIX, one edge:
  - Register sum_diff, br_Ca_out = c, neg and magnitude.
  - done=1 for exactly the following cycle; busy=0; next state IDLE.
- Latency:
  - Start accepted at edge k; bits are processed on edges k+1..k+WIDTH; FIX completes at edge k+WIDTH+1.
  - done is high between edges k+WIDTH+1 and k+WIDTH+2. For WIDTH=4 that is 6 edges from start to done.
- busy is high from after edge k until after edge k+WIDTH+1, so it deasserts in the same cycle done asserts.
- start while busy is ignored and not queued; operand changes while busy have no effect.
- start high during the done cycle is accepted, since the block is in IDLE: back-to-back throughput is WIDTH+2 cycles per operation.
- Results hold stable until the next FIX edge or reset.
- Arithmetic is modulo 2^WIDTH. Overflow is visible only through br_Ca_out; no signed-overflow flag.
- Subtract with A=B gives sum_diff=0, br_Ca_out=1, neg=0, magnitude=0.
- Most-negative case (A=0, B=2^WIDTH-1, subtract) gives magnitude 2^WIDTH-1 with no truncation loss. Magnitude is always representable because operands are unsigned.
- Reset mid-operation aborts it: no done pulse, outputs cleared, next start works normally.

Test Plan:
- Reset, then add 9+8: one start pulse -> done exactly 6 cycles later; sum_diff=1, br_Ca_out=1, neg=0, magnitude=1.
- Subtract 10-3 -> sum_diff=7, br_Ca_out=1, neg=0, magnitude=7. Subtract 3-5 -> sum_diff=14, br_Ca_out=0, neg=1, magnitude=2.
- Boundaries:
  - 15+15 -> sum_diff=14, carry 1.
  - 15-15 -> sum_diff=0, br_Ca_out=1, neg=0.
  - 0-15 -> sum_diff=1, br_Ca_out=0, neg=1, magnitude=15.
  - 0+0 -> all zero, done still pulses.
- Handshake:
  - start held high continuously with changing operands -> a new operation every 6 cycles, each using operands present at its accepted edge.
  - Mid-operation changes to a, b and control_signal are ignored.
- Reset asserted at the third SHIFT cycle -> no done, outputs 0 next cycle. A subsequent 7-2 gives sum_diff=5, br_Ca_out=1, done 6 cycles after its start.
- Exhaustive self-check, all 512 {a, b, control_signal} combinations:
  - {br_Ca_out, sum_diff} matches a + (b XOR {4{M}}) + M.
  - neg and magnitude match the decode rule.
  - done width is always 1 cycle.
